// File: rtl/bits2bytes_pkg.sv
// ----------------------------------------------------------------------------
// bits2bytes_pkg
//   Shared constants and types for the bits2bytes stream controller.
//   BYTE_W  : width of one output byte
//   state_e : sequencer states IDLE -> FETCH -> EMIT -> (FETCH | DONE) -> IDLE
// ----------------------------------------------------------------------------
package bits2bytes_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : bits2bytes_pkg

// File: rtl/bits2bytes.sv
// ----------------------------------------------------------------------------
// bits2bytes
//   Regroups a packed N_BYTES*8-bit word into an array of bytes, byte 0 being
//   the least significant byte of the word. Purely combinational.
//   Ports:
//     word_i   in   N_BYTES*BYTE_W   packed input word
//     bytes_o  out  N_BYTES x BYTE_W bytes_o[k] = word_i[k*BYTE_W +: BYTE_W]
// ----------------------------------------------------------------------------
module bits2bytes
    import bits2bytes_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES*BYTE_W-1:0]          word_i,
    output logic [N_BYTES-1:0][BYTE_W-1:0]     bytes_o
);

    for (genvar k = 0; k < N_BYTES; k++) begin : g_byte
        assign bytes_o[k] = word_i[k*BYTE_W +: BYTE_W];
    end

endmodule : bits2bytes

// File: rtl/bits2bytes_stream_ctrl.sv
// ----------------------------------------------------------------------------
// bits2bytes_stream_ctrl
//   Streams a message of len_i bytes out of packed N_BYTES*8-bit words.
//   One word is fetched per word handshake, then emitted LSB byte first, one
//   byte per byte handshake. The final byte is flagged with byte_last_o and
//   done_o pulses for one cycle afterwards. Unused bytes of a partial final
//   word are dropped and no further word is fetched.
//   Ports:
//     clk_i, rst_ni            clock, synchronous active-low reset
//     start_i, len_i           start a message of len_i bytes (IDLE only)
//     busy_o, done_o           busy while not IDLE, one-cycle end pulse
//     word_valid_i/ready_o/i   input word stream
//     byte_valid_o/ready_i/o   output byte stream
//     byte_last_o              marks the final byte of the message
//     byte_cnt_o               bytes emitted since last start (optional)
//   Optional feature: define BITS2BYTES_CTRL_BYTE_CNT_EN to add byte_cnt_o.
// ----------------------------------------------------------------------------
module bits2bytes_stream_ctrl
    import bits2bytes_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int LEN_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            len_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        word_valid_i,
    output logic                        word_ready_o,
    input  logic [N_BYTES*BYTE_W-1:0]   word_i,
    output logic                        byte_valid_o,
    input  logic                        byte_ready_i,
    output logic [BYTE_W-1:0]           byte_o,
    output logic                        byte_last_o
`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
    ,
    output logic [LEN_W-1:0]            byte_cnt_o
`endif
);

    localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_e                          state_q;
    logic [LEN_W-1:0]                rem_q;
    logic [IDX_W-1:0]                idx_q;
    logic [N_BYTES*BYTE_W-1:0]       word_q;
    logic [N_BYTES-1:0][BYTE_W-1:0]  word_bytes;

    bits2bytes #(.N_BYTES(N_BYTES)) u_bits2bytes (
        .word_i  (word_q),
        .bytes_o (word_bytes)
    );

    // The byte is read straight from the buffered word, so it is stable for
    // as long as idx_q and word_q hold, i.e. throughout a stall.
    assign byte_o = word_bytes[idx_q];

    // Outputs are registered: each transition sets the flags that describe
    // the state being entered, so they line up with state_q.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking ones would create order-dependent
    // races between the flags and the counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            idx_q        <= '0;
            // NOTE: the word buffer is cleared on reset so byte_o reads 0
            // after reset and no byte of an aborted message can leak out.
            word_q       <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            word_ready_o <= 1'b0;
            byte_valid_o <= 1'b0;
            byte_last_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        if (len_i != '0) begin
                            rem_q        <= len_i;
                            word_ready_o <= 1'b1;
                            state_q      <= FETCH;
                        end else begin
                            done_o  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (word_valid_i) begin
                        word_q       <= word_i;
                        idx_q        <= '0;
                        word_ready_o <= 1'b0;
                        byte_valid_o <= 1'b1;
                        byte_last_o  <= (rem_q == LEN_W'(1));
                        state_q      <= EMIT;
                    end
                end
                EMIT: begin
                    if (byte_ready_i) begin
                        rem_q <= rem_q - LEN_W'(1);
                        idx_q <= idx_q + IDX_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            byte_valid_o <= 1'b0;
                            byte_last_o  <= 1'b0;
                            done_o       <= 1'b1;
                            state_q      <= DONE;
                        end else if (idx_q == IDX_W'(N_BYTES - 1)) begin
                            byte_valid_o <= 1'b0;
                            byte_last_o  <= 1'b0;
                            word_ready_o <= 1'b1;
                            state_q      <= FETCH;
                        end else begin
                            // Next byte is the last one when two remain now.
                            byte_last_o  <= (rem_q == LEN_W'(2));
                        end
                    end
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
    // Cleared on an accepted start, counts byte handshakes, and holds its
    // final value after the message until the next start.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            byte_cnt_o <= '0;
        end else if (state_q == IDLE && start_i) begin
            byte_cnt_o <= '0;
        end else if (byte_valid_o && byte_ready_i) begin
            byte_cnt_o <= byte_cnt_o + LEN_W'(1);
        end
    end
`endif

endmodule : bits2bytes_stream_ctrl

// File: tb/tb_bits2bytes_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bits2bytes_stream_ctrl
//   Directed testbench for bits2bytes_stream_ctrl with N_BYTES=4, LEN_W=16.
//   Inputs are driven 1 time unit after each rising edge and outputs are
//   sampled at the same point, so both are clear of the active edge.
// ----------------------------------------------------------------------------
module tb_bits2bytes_stream_ctrl;

    localparam int N_BYTES = 4;
    localparam int LEN_W   = 16;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    start_i;
    logic [LEN_W-1:0]        len_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    word_valid_i;
    logic                    word_ready_o;
    logic [N_BYTES*8-1:0]    word_i;
    logic                    byte_valid_o;
    logic                    byte_ready_i;
    logic [7:0]              byte_o;
    logic                    byte_last_o;
`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
    logic [LEN_W-1:0]        byte_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    // Stimulus tables shared by the message scenarios.
    logic [31:0] words_t [4];
    logic [7:0]  exp_t   [8];

    always #5 clk_i = ~clk_i;

    bits2bytes_stream_ctrl #(.N_BYTES(N_BYTES), .LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .word_i       (word_i),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_o       (byte_o),
        .byte_last_o  (byte_last_o)
`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
        ,
        .byte_cnt_o   (byte_cnt_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        logic [12:0] obs;
        obs = {busy_o, done_o, word_ready_o, byte_valid_o, byte_last_o, byte_o};
        total++;
        if (obs !== 13'd0) begin
            bad++;
            $display("FAIL %s: outputs {busy,done,wrdy,bval,blast,byte}=%h expected 0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        len_i        = '0;
        word_valid_i = 1'b0;
        word_i       = '0;
        byte_ready_i = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset_state");
`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
        total++;
        if (byte_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL reset_byte_cnt: got %0d expected 0", byte_cnt_o);
        end
`endif
        rst_ni = 1'b1;
        tick();
    endtask

    // Runs one message using words_t/exp_t, optionally with byte_ready_i
    // toggling and with a stray start pulse in the middle of the message.
    task automatic run_msg(input string name, input int len, input int n_words,
                           input bit stall, input bit mid_start);
        int         widx      = 0;
        int         nb        = 0;
        int         last_hs   = -10;
        int         done_cnt  = 0;
        int         done_slot = -1;
        bit         extra_rdy = 1'b0;
        bit         hold_pend = 1'b0;
        logic [7:0] hold_b;
        logic       hold_l;
        logic [7:0] got      [8];
        logic       got_last [8];

        start_i = 1'b1;
        len_i   = LEN_W'(len);
        tick();
        start_i = 1'b0;
        for (int slot = 1; slot < 200; slot++) begin
            if (hold_pend) begin
                total++;
                if (!(byte_valid_o === 1'b1 && byte_o === hold_b && byte_last_o === hold_l)) begin
                    bad++;
                    $display("FAIL %s stall_hold slot %0d: valid=%b byte=%h last=%b expected valid=1 byte=%h last=%b",
                             name, slot, byte_valid_o, byte_o, byte_last_o, hold_b, hold_l);
                end
                hold_pend = 1'b0;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_slot = slot;
            end
            if (done_cnt > 0 && busy_o === 1'b0) break;

            if (mid_start && slot == 3) begin
                start_i = 1'b1;
                len_i   = 16'd2;
            end else begin
                start_i = 1'b0;
            end

            if (word_ready_o === 1'b1 && widx < n_words) begin
                word_valid_i = 1'b1;
                word_i       = words_t[widx];
                widx++;
            end else begin
                word_valid_i = 1'b0;
                if (word_ready_o === 1'b1) extra_rdy = 1'b1;
            end

            byte_ready_i = stall ? ((slot % 2) == 1) : 1'b1;
            if (byte_valid_o === 1'b1) begin
                if (byte_ready_i) begin
                    if (nb < 8) begin
                        got[nb]      = byte_o;
                        got_last[nb] = byte_last_o;
                    end
                    nb++;
                    last_hs = slot;
                end else begin
                    hold_pend = 1'b1;
                    hold_b    = byte_o;
                    hold_l    = byte_last_o;
                end
            end
            tick();
        end
        start_i      = 1'b0;
        word_valid_i = 1'b0;
        byte_ready_i = 1'b0;

        total++;
        if (nb != len) begin
            bad++;
            $display("FAIL %s byte_count: got %0d expected %0d", name, nb, len);
        end
        for (int i = 0; i < len && i < nb && i < 8; i++) begin
            total++;
            if (got[i] !== exp_t[i] || got_last[i] !== (i == len - 1)) begin
                bad++;
                $display("FAIL %s byte[%0d]: got %h last=%b expected %h last=%b",
                         name, i, got[i], got_last[i], exp_t[i], (i == len - 1));
            end
        end
        total++;
        if (widx != n_words || extra_rdy) begin
            bad++;
            $display("FAIL %s words: accepted %0d extra_ready=%b expected %0d extra_ready=0",
                     name, widx, extra_rdy, n_words);
        end
        total++;
        if (done_cnt != 1 || done_slot != last_hs + 1) begin
            bad++;
            $display("FAIL %s done: pulses %0d at slot %0d expected 1 at slot %0d",
                     name, done_cnt, done_slot, last_hs + 1);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_after: got %b expected 0", name, busy_o);
        end
    endtask

    task automatic load_case1();
        words_t[0] = 32'h89AB_CDEF;
        exp_t[0] = 8'hEF; exp_t[1] = 8'hCD; exp_t[2] = 8'hAB; exp_t[3] = 8'h89;
    endtask

    task automatic load_case2();
        words_t[0] = 32'h0302_0100;
        words_t[1] = 32'h0706_0504;
        exp_t[0] = 8'h00; exp_t[1] = 8'h01; exp_t[2] = 8'h02;
        exp_t[3] = 8'h03; exp_t[4] = 8'h04; exp_t[5] = 8'h05;
    endtask

    task automatic test_full_word();
        load_case1();
        run_msg("full_word", 4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_partial_word();
        load_case2();
        run_msg("partial_word", 6, 2, 1'b0, 1'b0);
`ifdef BITS2BYTES_CTRL_BYTE_CNT_EN
        total++;
        if (byte_cnt_o !== 16'd6) begin
            bad++;
            $display("FAIL byte_cnt: got %0d expected 6", byte_cnt_o);
        end
`endif
    endtask

    task automatic test_stall();
        load_case2();
        run_msg("stall", 6, 2, 1'b1, 1'b0);
    endtask

    task automatic test_mid_start();
        load_case2();
        run_msg("mid_start", 6, 2, 1'b0, 1'b1);
    endtask

    task automatic test_len_zero();
        int  done_cnt = 0;
        bit  saw_rdy  = 1'b0;
        start_i = 1'b1;
        len_i   = 16'd0;
        tick();
        start_i = 1'b0;
        for (int slot = 1; slot <= 5; slot++) begin
            if (done_o === 1'b1) done_cnt++;
            if (word_ready_o === 1'b1) saw_rdy = 1'b1;
            tick();
        end
        total++;
        if (done_cnt != 1 || saw_rdy) begin
            bad++;
            $display("FAIL len_zero: done pulses %0d word_ready seen %b expected 1 and 0",
                     done_cnt, saw_rdy);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL len_zero busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int nb = 0;
        load_case1();
        start_i = 1'b1;
        len_i   = 16'd4;
        tick();
        start_i = 1'b0;
        for (int slot = 1; slot < 50 && nb < 2; slot++) begin
            word_valid_i = word_ready_o;
            word_i       = words_t[0];
            byte_ready_i = 1'b1;
            if (byte_valid_o === 1'b1) nb++;
            tick();
        end
        word_valid_i = 1'b0;
        byte_ready_i = 1'b0;
        total++;
        if (nb != 2) begin
            bad++;
            $display("FAIL reset_mid progress: got %0d bytes expected 2", nb);
        end
        rst_ni = 1'b0;
        tick();
        check_outputs_zero("reset_mid");
        rst_ni = 1'b1;
        tick();
        run_msg("after_reset", 4, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_word();
        test_stall();
        test_len_zero();
        test_reset_mid();
        test_mid_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bits2bytes_stream_ctrl
